// File: rtl/aes128_key_expand_seq.sv
// Iterative AES-128 key schedule: computes one round key per clock after a
// load and holds the round-0 key plus the ten round keys in registers for the
// unrolled encryption pipeline downstream.
module aes128_key_expand_seq #(
    parameter bit ZEROIZE_ON_LOAD = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_valid,
    output logic [127:0] key_out,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] rk [0:10];
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  w0, w1, w2, w3, t;

    // Byte b sits at bit offset (255-b)*8, and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key from the key written on the previous step.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (cnt == 4'(i + 1)) prev_key = rk[i];
        end
        w0 = prev_key[127:96];
        w1 = prev_key[95:64];
        w2 = prev_key[63:32];
        w3 = prev_key[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        next_key[127:96] = w0 ^ t;
        next_key[95:64]  = w0 ^ t ^ w1;
        next_key[63:32]  = w0 ^ t ^ w1 ^ w2;
        next_key[31:0]   = w0 ^ t ^ w1 ^ w2 ^ w3;
    end

    // Control FSM and key register file; loads are ignored while expanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rcon       <= 8'h01;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_load) begin
                        rk[0]      <= key_in;
                        cnt        <= 4'd1;
                        rcon       <= 8'h01;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        if (ZEROIZE_ON_LOAD) begin
                            for (int i = 1; i <= 10; i++) rk[i] <= '0;
                        end
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (cnt == 4'(i)) rk[i] <= next_key;
                    end
                    rcon <= xtime(rcon);
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_out     = rk[0];
    assign round1_key  = rk[1];
    assign round2_key  = rk[2];
    assign round3_key  = rk[3];
    assign round4_key  = rk[4];
    assign round5_key  = rk[5];
    assign round6_key  = rk[6];
    assign round7_key  = rk[7];
    assign round8_key  = rk[8];
    assign round9_key  = rk[9];
    assign round10_key = rk[10];

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Bench for aes128_key_expand_seq: directed FIPS-197 vectors, expected key
// sets queued at load time and compared when keys_valid rises.
module tb_aes128_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_valid;
    logic [127:0] key_out;
    logic [127:0] round1_key, round2_key, round3_key, round4_key, round5_key;
    logic [127:0] round6_key, round7_key, round8_key, round9_key, round10_key;

    typedef struct {
        logic [127:0] k0;
        logic [127:0] r1;
        logic [127:0] r10;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_cycles = 0;
    logic prev_valid = 1'b0;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R1_Z    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R10_Z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1_C1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] R10_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes128_key_expand_seq #(.ZEROIZE_ON_LOAD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .busy(busy), .keys_valid(keys_valid), .key_out(key_out),
        .round1_key(round1_key), .round2_key(round2_key), .round3_key(round3_key),
        .round4_key(round4_key), .round5_key(round5_key), .round6_key(round6_key),
        .round7_key(round7_key), .round8_key(round8_key), .round9_key(round9_key),
        .round10_key(round10_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] all_keys_or();
        return key_out | round1_key | round2_key | round3_key | round4_key | round5_key
             | round6_key | round7_key | round8_key | round9_key | round10_key;
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},  128'(busy), 128'd0);
        chk({tag, "_valid"}, 128'(keys_valid), 128'd0);
        chk({tag, "_keys"},  all_keys_or(), 128'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse key_load for one accepting edge; optionally queue the expected set.
    task automatic load(input logic [127:0] k, input bit push,
                        input logic [127:0] r1, input logic [127:0] r10);
        exp_t e;
        if (push) begin
            e.k0 = k; e.r1 = r1; e.r10 = r10;
            exp_q.push_back(e);
        end
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_in   = ~k;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!keys_valid && n < 30) begin
            tick();
            n++;
        end
        if (!keys_valid) chk({tag, "_timeout"}, 128'd0, 128'd1);
        tick();
    endtask

    // Monitor: counts busy cycles and checks the key set when keys_valid rises.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            busy_cycles = 0;
        end else begin
            if (busy && keys_valid) chk("busy_and_valid", 128'd1, 128'd0);
            if (busy) busy_cycles++;
            if (keys_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_len", 128'(busy_cycles), 128'd10);
                    chk("key_out",  key_out,     e.k0);
                    chk("round1",   round1_key,  e.r1);
                    chk("round10",  round10_key, e.r10);
                end
                busy_cycles = 0;
            end
        end
        prev_valid = keys_valid;
    end

    initial begin
        rst_n    = 1'b0;
        key_in   = '0;
        key_load = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) tick();
            check_cleared("idle_stable");
        end

        // FIPS-197 A.1
        load(KEY_A1, 1'b1, R1_A1, R10_A1);
        chk("a1_busy_after_accept", 128'(busy), 128'd1);
        wait_done("a1");

        // Back-to-back: C.1 loaded from DONE, keys_valid drops on accept edge
        load(KEY_C1, 1'b1, R1_C1, R10_C1);
        chk("c1_valid_drop", 128'(keys_valid), 128'd0);
        chk("c1_key_out_now", key_out, KEY_C1);
        wait_done("c1");

        // All-zero key
        load(128'd0, 1'b1, R1_Z, R10_Z);
        wait_done("zero");

        // Loads during expansion are ignored
        load(KEY_A1, 1'b1, R1_A1, R10_A1);
        tick();
        key_in = 128'hdeadbeef_00112233_44556677_8899aabb;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (3) tick();
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("ign_key_out", key_out, KEY_A1);
        wait_done("ign");

        // Reset mid-expansion aborts; nothing queued for the aborted run
        load(KEY_C1, 1'b0, '0, '0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_cleared("mid_reset");
        rst_n = 1'b1;
        tick();
        check_cleared("post_reset");
        load(KEY_A1, 1'b1, R1_A1, R10_A1);
        wait_done("after_rst");

        repeat (3) tick();
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
